// File: rtl/teclado_clave.sv
// -----------------------------------------------------------------------------
// teclado_clave
//
// Two-digit PIN entry front end for a keypad. Collects two BCD digits,
// waits for the "enviar" key, and then presents the assembled PIN to an
// access controller until that controller acknowledges it. A partial PIN
// is thrown away if the user stops typing for TIEMPO_ESPERA cycles.
//
// Parameters
//   TIEMPO_ESPERA       idle cycles tolerated between keys (2..65535)
//
// Ports
//   clock               single clock, rising edge
//   reset               synchronous, active-low reset
//   tecla_valida        one-cycle strobe, tecla_codigo valid this cycle
//   tecla_codigo[3:0]   0x0-0x9 digit, 0xA borrar, 0xB enviar, 0xC-0xF illegal
//   clave_aceptada      acknowledge from the access controller
//   clave_ingresada[7:0] assembled PIN (first digit [7:4], second [3:0]),
//                        0x00 whenever no PIN is being presented
//   clave_lista         high while clave_ingresada carries a PIN
//   digitos_ingresados[1:0] number of digits currently held
//   senal_error_tecla   one-cycle pulse on a rejected key
//   senal_timeout       one-cycle pulse when a partial PIN is discarded
//
// Every output is a flop; its next value is derived from the next state
// so that a key sampled on an edge is reflected right after that edge.
// -----------------------------------------------------------------------------
module teclado_clave #(
    parameter int unsigned TIEMPO_ESPERA = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tecla_valida,
    input  logic [3:0] tecla_codigo,
    input  logic       clave_aceptada,
    output logic [7:0] clave_ingresada,
    output logic       clave_lista,
    output logic [1:0] digitos_ingresados,
    output logic       senal_error_tecla,
    output logic       senal_timeout
);

    // Counter wide enough to hold TIEMPO_ESPERA itself; it only ever climbs
    // to TIEMPO_ESPERA-1, at which point the expiry fires.
    localparam int unsigned CNT_W = $clog2(TIEMPO_ESPERA + 1);
    localparam logic [CNT_W-1:0] CNT_LIMITE = CNT_W'(TIEMPO_ESPERA - 1);
    localparam logic [CNT_W-1:0] CNT_UNO    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CERO   = CNT_W'(0);

    localparam logic [3:0] COD_BORRAR = 4'hA;
    localparam logic [3:0] COD_ENVIAR = 4'hB;
    localparam logic [3:0] COD_MAX_DIGITO = 4'h9;

    typedef enum logic [1:0] {
        ESPERA_PRIMER_DIGITO  = 2'd0,
        ESPERA_SEGUNDO_DIGITO = 2'd1,
        ESPERA_ENVIAR         = 2'd2,
        CLAVE_LISTA           = 2'd3
    } estado_t;

    // State and datapath flops
    estado_t          estado_q, estado_d;
    logic [7:0]       buffer_q, buffer_d;
    logic [CNT_W-1:0] contador_q, contador_d;

    // Output flops
    logic [7:0] clave_ingresada_q, clave_ingresada_d;
    logic       clave_lista_q, clave_lista_d;
    logic [1:0] digitos_q, digitos_d;
    logic       error_q, error_d;
    logic       timeout_q, timeout_d;

    // Key decode and per-cycle events
    logic es_digito_s;
    logic es_borrar_s;
    logic es_enviar_s;
    logic expira_s;
    logic evento_error_s;
    logic evento_timeout_s;
    logic recolectando_s;

    // Key classification; codes 0xC-0xF fall into none of the three classes.
    always_comb begin
        es_digito_s = (tecla_codigo <= COD_MAX_DIGITO);
        es_borrar_s = (tecla_codigo == COD_BORRAR);
        es_enviar_s = (tecla_codigo == COD_ENVIAR);
    end

    // Idle expiry: the counter only advances in the two partial-PIN states,
    // and CNT_LIMITE >= 1, so a zero count elsewhere never looks expired.
    always_comb begin
        recolectando_s = (estado_q == ESPERA_SEGUNDO_DIGITO) ||
                         (estado_q == ESPERA_ENVIAR);
        expira_s       = recolectando_s && (contador_q == CNT_LIMITE);
    end

    // State register plus all datapath and output flops.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q          <= ESPERA_PRIMER_DIGITO;
            buffer_q          <= 8'h00;
            contador_q        <= CNT_CERO;
            clave_ingresada_q <= 8'h00;
            clave_lista_q     <= 1'b0;
            digitos_q         <= 2'd0;
            error_q           <= 1'b0;
            timeout_q         <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            buffer_q          <= buffer_d;
            contador_q        <= contador_d;
            clave_ingresada_q <= clave_ingresada_d;
            clave_lista_q     <= clave_lista_d;
            digitos_q         <= digitos_d;
            error_q           <= error_d;
            timeout_q         <= timeout_d;
        end
    end

    // Next-state and buffer logic. A key on the expiry cycle is handled as a
    // key, so the timeout branch is only reached when tecla_valida is low.
    always_comb begin
        estado_d         = estado_q;
        buffer_d         = buffer_q;
        evento_error_s   = 1'b0;
        evento_timeout_s = 1'b0;
        case (estado_q)
            ESPERA_PRIMER_DIGITO: begin
                if (tecla_valida) begin
                    if (es_digito_s) begin
                        buffer_d = {tecla_codigo, 4'h0};
                        estado_d = ESPERA_SEGUNDO_DIGITO;
                    end else if (es_borrar_s) begin
                        buffer_d = 8'h00;
                        estado_d = ESPERA_PRIMER_DIGITO;
                    end else begin
                        // enviar with no digits, or an illegal code
                        evento_error_s = 1'b1;
                    end
                end else begin
                    estado_d = ESPERA_PRIMER_DIGITO;
                end
            end
            ESPERA_SEGUNDO_DIGITO: begin
                if (tecla_valida) begin
                    if (es_digito_s) begin
                        buffer_d = {buffer_q[7:4], tecla_codigo};
                        estado_d = ESPERA_ENVIAR;
                    end else if (es_borrar_s) begin
                        buffer_d = 8'h00;
                        estado_d = ESPERA_PRIMER_DIGITO;
                    end else begin
                        // enviar with one digit, or an illegal code
                        evento_error_s = 1'b1;
                    end
                end else if (expira_s) begin
                    buffer_d         = 8'h00;
                    estado_d         = ESPERA_PRIMER_DIGITO;
                    evento_timeout_s = 1'b1;
                end else begin
                    estado_d = ESPERA_SEGUNDO_DIGITO;
                end
            end
            ESPERA_ENVIAR: begin
                if (tecla_valida) begin
                    if (es_enviar_s) begin
                        estado_d = CLAVE_LISTA;
                    end else if (es_borrar_s) begin
                        buffer_d = 8'h00;
                        estado_d = ESPERA_PRIMER_DIGITO;
                    end else begin
                        // a third digit, or an illegal code
                        evento_error_s = 1'b1;
                    end
                end else if (expira_s) begin
                    buffer_d         = 8'h00;
                    estado_d         = ESPERA_PRIMER_DIGITO;
                    evento_timeout_s = 1'b1;
                end else begin
                    estado_d = ESPERA_ENVIAR;
                end
            end
            CLAVE_LISTA: begin
                // Keys are dropped silently while a PIN is presented.
                if (clave_aceptada) begin
                    buffer_d = 8'h00;
                    estado_d = ESPERA_PRIMER_DIGITO;
                end else begin
                    estado_d = CLAVE_LISTA;
                end
            end
            default: begin
                buffer_d = 8'h00;
                estado_d = ESPERA_PRIMER_DIGITO;
            end
        endcase
    end

    // Idle counter: restarts on any key or state change, advances only
    // while a partial PIN is held, and saturates rather than wrapping.
    always_comb begin
        if (tecla_valida || (estado_d != estado_q)) begin
            contador_d = CNT_CERO;
        end else if (recolectando_s) begin
            if (contador_q < CNT_LIMITE) begin
                contador_d = contador_q + CNT_UNO;
            end else begin
                contador_d = contador_q;
            end
        end else begin
            contador_d = CNT_CERO;
        end
    end

    // Output decode from the upcoming state so outputs land one edge after
    // the key that caused them.
    always_comb begin
        error_d   = evento_error_s;
        timeout_d = evento_timeout_s;
        case (estado_d)
            ESPERA_PRIMER_DIGITO: begin
                digitos_d         = 2'd0;
                clave_lista_d     = 1'b0;
                clave_ingresada_d = 8'h00;
            end
            ESPERA_SEGUNDO_DIGITO: begin
                digitos_d         = 2'd1;
                clave_lista_d     = 1'b0;
                clave_ingresada_d = 8'h00;
            end
            ESPERA_ENVIAR: begin
                digitos_d         = 2'd2;
                clave_lista_d     = 1'b0;
                clave_ingresada_d = 8'h00;
            end
            CLAVE_LISTA: begin
                digitos_d         = 2'd2;
                clave_lista_d     = 1'b1;
                clave_ingresada_d = buffer_d;
            end
            default: begin
                digitos_d         = 2'd0;
                clave_lista_d     = 1'b0;
                clave_ingresada_d = 8'h00;
            end
        endcase
    end

    assign clave_ingresada    = clave_ingresada_q;
    assign clave_lista        = clave_lista_q;
    assign digitos_ingresados = digitos_q;
    assign senal_error_tecla  = error_q;
    assign senal_timeout      = timeout_q;

endmodule

// File: tb/tb_teclado_clave.sv
// -----------------------------------------------------------------------------
// tb_teclado_clave
//
// Bench for teclado_clave with TIEMPO_ESPERA = 8. A table of directed
// vectors with hand-computed expectations, hand-written timeout and reset
// sequences, and a randomized run, all checked against a queue-based
// reference model of the PIN entry rules.
// -----------------------------------------------------------------------------
module tb_teclado_clave;

    localparam int unsigned T_ESPERA = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla_codigo = 4'h0;
    logic       clave_aceptada = 1'b0;
    logic [7:0] clave_ingresada;
    logic       clave_lista;
    logic [1:0] digitos_ingresados;
    logic       senal_error_tecla;
    logic       senal_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    teclado_clave #(.TIEMPO_ESPERA(T_ESPERA)) dut (
        .clock              (clock),
        .reset              (reset),
        .tecla_valida       (tecla_valida),
        .tecla_codigo       (tecla_codigo),
        .clave_aceptada     (clave_aceptada),
        .clave_ingresada    (clave_ingresada),
        .clave_lista        (clave_lista),
        .digitos_ingresados (digitos_ingresados),
        .senal_error_tecla  (senal_error_tecla),
        .senal_timeout      (senal_timeout)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int  m_dig[$];      // digits held, in entry order
    bit  m_lista = 0;   // PIN being presented
    int  m_idle  = 0;   // consecutive key-less cycles with a partial PIN
    bit  m_err   = 0;
    bit  m_to    = 0;

    task automatic modelo(input logic tv, input logic [3:0] c,
                          input logic ack, input logic rst);
        int code;
        code  = int'(c);
        m_err = 0;
        m_to  = 0;
        if (!rst) begin
            m_dig.delete();
            m_lista = 0;
            m_idle  = 0;
        end else if (m_lista) begin
            m_idle = 0;
            if (ack) begin
                m_lista = 0;
                m_dig.delete();
            end
        end else if (tv) begin
            m_idle = 0;
            if (code <= 9) begin
                if (m_dig.size() < 2) m_dig.push_back(code);
                else m_err = 1;
            end else if (code == 10) begin
                m_dig.delete();
            end else if (code == 11) begin
                if (m_dig.size() == 2) m_lista = 1;
                else m_err = 1;
            end else begin
                m_err = 1;
            end
        end else if (m_dig.size() > 0) begin
            m_idle++;
            if (m_idle == int'(T_ESPERA)) begin
                m_dig.delete();
                m_to   = 1;
                m_idle = 0;
            end
        end
    endtask

    function automatic logic [7:0] m_clave();
        if (m_lista) return 8'((m_dig[0] << 4) | m_dig[1]);
        return 8'h00;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nombre, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nombre, $time, act, exp);
        end
    endtask

    task automatic chk_modelo(input string etiqueta);
        chk({etiqueta, ".clave"},   clave_ingresada,          m_clave());
        chk({etiqueta, ".lista"},   {7'd0, clave_lista},      {7'd0, m_lista});
        chk({etiqueta, ".digitos"}, {6'd0, digitos_ingresados}, 8'(m_dig.size()));
        chk({etiqueta, ".error"},   {7'd0, senal_error_tecla}, {7'd0, m_err});
        chk({etiqueta, ".timeout"}, {7'd0, senal_timeout},    {7'd0, m_to});
    endtask

    // One clock: drive inputs, let the DUT and model take the edge, then
    // sample just after the edge.
    task automatic ciclo(input logic tv, input logic [3:0] c,
                         input logic ack, input logic rst, input string etiqueta);
        tecla_valida   = tv;
        tecla_codigo   = c;
        clave_aceptada = ack;
        reset          = rst;
        @(posedge clock);
        modelo(tv, c, ack, rst);
        #1;
        chk_modelo(etiqueta);
    endtask

    task automatic tecla(input logic [3:0] c, input string etiqueta);
        ciclo(1'b1, c, 1'b0, 1'b1, etiqueta);
    endtask

    task automatic ocioso(input int n, input string etiqueta);
        for (int k = 0; k < n; k++) ciclo(1'b0, 4'h0, 1'b0, 1'b1, etiqueta);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       tv;
        logic [3:0] cod;
        logic       ack;
        logic       rst;
        logic [7:0] e_clave;
        logic       e_lista;
        logic [1:0] e_dig;
        logic       e_err;
        logic       e_to;
    } vec_t;

    vec_t tabla[$];

    function automatic vec_t mk(logic tv, logic [3:0] cod, logic ack, logic rst,
                                logic [7:0] ec, logic el, logic [1:0] ed,
                                logic ee, logic et);
        vec_t v;
        v.tv = tv; v.cod = cod; v.ack = ack; v.rst = rst;
        v.e_clave = ec; v.e_lista = el; v.e_dig = ed; v.e_err = ee; v.e_to = et;
        return v;
    endfunction

    initial begin
        // reset then idle
        tabla.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        tabla.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        // 4, 7, enviar -> 0x47 held for 5 cycles, then acknowledged
        tabla.push_back(mk(1'b1, 4'h4, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h7, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'hB, 1'b0, 1'b1, 8'h47, 1'b1, 2'd2, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            tabla.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 8'h47, 1'b1, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        // illegal 0xE while empty; stray acknowledge while idle
        tabla.push_back(mk(1'b1, 4'hE, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0));
        tabla.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        // 3, early enviar rejected, 9, enviar -> 0x39; key ignored while presented
        tabla.push_back(mk(1'b1, 4'h3, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0));
        tabla.push_back(mk(1'b1, 4'h9, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'hB, 1'b0, 1'b1, 8'h39, 1'b1, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h5, 1'b0, 1'b1, 8'h39, 1'b1, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        // 5, 2, borrar, 1, 8, enviar -> 0x18; digit 6 while presented is silent
        tabla.push_back(mk(1'b1, 4'h5, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h2, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'hA, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h1, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h8, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'hB, 1'b0, 1'b1, 8'h18, 1'b1, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h6, 1'b0, 1'b1, 8'h18, 1'b1, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        // third digit and illegal code rejected in ESPERA_ENVIAR
        tabla.push_back(mk(1'b1, 4'h1, 1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h2, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
        tabla.push_back(mk(1'b1, 4'h3, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0));
        tabla.push_back(mk(1'b1, 4'hF, 1'b0, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0));
        tabla.push_back(mk(1'b1, 4'hB, 1'b0, 1'b1, 8'h12, 1'b1, 2'd2, 1'b0, 1'b0));
        // reset while presenting 0x12
        tabla.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
        tabla.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));

        for (int i = 0; i < tabla.size(); i++) begin
            ciclo(tabla[i].tv, tabla[i].cod, tabla[i].ack, tabla[i].rst, "vec_modelo");
            chk("vec_clave",   clave_ingresada,            tabla[i].e_clave);
            chk("vec_lista",   {7'd0, clave_lista},        {7'd0, tabla[i].e_lista});
            chk("vec_digitos", {6'd0, digitos_ingresados}, {6'd0, tabla[i].e_dig});
            chk("vec_error",   {7'd0, senal_error_tecla},  {7'd0, tabla[i].e_err});
            chk("vec_timeout", {7'd0, senal_timeout},      {7'd0, tabla[i].e_to});
        end

        // ---------------- timeout corners ----------------
        // key 5 then 7 idle cycles: still holding one digit
        tecla(4'h5, "to_tecla");
        ocioso(7, "to_espera");
        chk("to_antes_digitos", {6'd0, digitos_ingresados}, 8'd1);
        chk("to_antes_pulso",   {7'd0, senal_timeout},      8'd0);
        // 8th idle cycle discards the digit
        ocioso(1, "to_expira");
        chk("to_pulso",   {7'd0, senal_timeout},      8'd1);
        chk("to_digitos", {6'd0, digitos_ingresados}, 8'd0);
        ocioso(1, "to_post");
        chk("to_pulso_unico", {7'd0, senal_timeout}, 8'd0);

        // key on exactly the 8th idle cycle wins over the timeout
        tecla(4'h5, "pr_tecla");
        ocioso(7, "pr_espera");
        tecla(4'h6, "pr_octavo");
        chk("pr_sin_timeout", {7'd0, senal_timeout},      8'd0);
        chk("pr_digitos",     {6'd0, digitos_ingresados}, 8'd2);
        // then ESPERA_ENVIAR also times out after 8 idle cycles
        ocioso(8, "pr_enviar_to");
        chk("pr_enviar_pulso", {7'd0, senal_timeout}, 8'd1);

        // reset mid-entry with a concurrent key: no pulses, everything clear
        tecla(4'h2, "rs_tecla");
        ciclo(1'b1, 4'hE, 1'b1, 1'b0, "rs_reset");
        chk("rs_error",   {7'd0, senal_error_tecla},  8'd0);
        chk("rs_digitos", {6'd0, digitos_ingresados}, 8'd0);
        ocioso(1, "rs_post");

        // ---------------- randomized run ----------------
        for (int i = 0; i < 4000; i++) begin
            logic       tv;
            logic [3:0] c;
            logic       ack;
            logic       rst;
            tv  = ($urandom_range(0, 2) == 0);
            c   = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) != 0);
            ciclo(tv, c, ack, rst, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/teclado_clave.md
TECLADO_CLAVE -- requirements
Module: teclado_clave

Interface
REQ-001 Parameter: TIEMPO_ESPERA, default 1000, idle cycles allowed between keys before a partial PIN is discarded (legal range 2..65535).
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-004 tecla_valida  input  1  one-cycle strobe; tecla_codigo valid this cycle.
REQ-005 tecla_codigo  input  4  key code: 0x0-0x9 digit, 0xA borrar (clear), 0xB enviar (enter), 0xC-0xF illegal.
REQ-006 clave_aceptada  input  1  acknowledge from access controller; consumes the presented PIN.
REQ-007 clave_ingresada  output  8  assembled PIN, first digit in [7:4], second digit in [3:0] (BCD).
REQ-008 clave_lista  output  1  PIN valid; high while clave_ingresada is presented.
REQ-009 digitos_ingresados  output  2  digits currently held (0, 1, 2).
REQ-010 senal_error_tecla  output  1  one-cycle pulse on a rejected key.
REQ-011 senal_timeout  output  1  one-cycle pulse when a partial PIN is discarded by timeout.

Function
REQ-012 The block SHALL implement states ESPERA_PRIMER_DIGITO, ESPERA_SEGUNDO_DIGITO, ESPERA_ENVIAR, CLAVE_LISTA; all outputs registered.
REQ-013 ESPERA_PRIMER_DIGITO + digit d: store d in buffer[7:4], digitos_ingresados=1, go ESPERA_SEGUNDO_DIGITO.
REQ-014 ESPERA_SEGUNDO_DIGITO + digit d: store d in buffer[3:0], digitos_ingresados=2, go ESPERA_ENVIAR.
REQ-015 ESPERA_ENVIAR + enviar: go CLAVE_LISTA; clave_lista=1 and clave_ingresada=buffer on the cycle after the strobe edge (latency 1).
REQ-016 Rejected keys (pulse senal_error_tecla next cycle, no state/buffer change): enviar in ESPERA_PRIMER_DIGITO or ESPERA_SEGUNDO_DIGITO; digit in ESPERA_ENVIAR; codes 0xC-0xF in any collecting state.
REQ-017 borrar in any collecting state: buffer=0x00, digitos_ingresados=0, go ESPERA_PRIMER_DIGITO; no error pulse.
REQ-018 CLAVE_LISTA: clave_lista and clave_ingresada SHALL hold stable until clave_aceptada=1; all keys ignored silently (no error pulse).
REQ-019 CLAVE_LISTA + clave_aceptada: next cycle clave_lista=0, clave_ingresada=0x00, buffer=0x00, digitos_ingresados=0, go ESPERA_PRIMER_DIGITO.
REQ-020 clave_aceptada outside CLAVE_LISTA SHALL be ignored.
REQ-021 clave_ingresada SHALL read 0x00 in every state except CLAVE_LISTA.
REQ-022 Idle counter: cleared on every tecla_valida and on every state entry; increments each cycle in ESPERA_SEGUNDO_DIGITO/ESPERA_ENVIAR; held at 0 in the other states; width sized for TIEMPO_ESPERA, never wraps.
REQ-023 When TIEMPO_ESPERA consecutive cycles pass without tecla_valida in ESPERA_SEGUNDO_DIGITO/ESPERA_ENVIAR: clear buffer and count, go ESPERA_PRIMER_DIGITO, pulse senal_timeout for one cycle.
REQ-024 tecla_valida on the expiry cycle SHALL take priority: key processed, no timeout.
REQ-025 senal_error_tecla and senal_timeout SHALL never be high on the same cycle and never longer than one cycle per event.

Reset
REQ-026 reset=0 at a rising edge SHALL force ESPERA_PRIMER_DIGITO, buffer=0x00, idle counter=0, and all outputs 0 on the following cycle, overriding any concurrent key, acknowledge, or timeout.
REQ-027 Reset asserted mid-entry or in CLAVE_LISTA SHALL discard the PIN with no error or timeout pulse.

Verification (TIEMPO_ESPERA=8)
REQ-028 Keys 4,7,enviar -> clave_ingresada=0x47, clave_lista=1, digitos_ingresados=2; clave_aceptada after 5 cycles -> next cycle clave_lista=0, clave_ingresada=0x00.
REQ-029 Keys 3,enviar -> senal_error_tecla one pulse, state ESPERA_SEGUNDO_DIGITO; then 9,enviar -> 0x39 presented.
REQ-030 Keys 5,2,borrar,1,8,enviar -> 0x18 presented; digit 6 during CLAVE_LISTA -> no change, no error.
REQ-031 Key 5 then 8 idle cycles -> senal_timeout one pulse, digitos_ingresados=0; key on exactly the 8th idle cycle -> no timeout.
REQ-032 Key 0xE in ESPERA_PRIMER_DIGITO -> error pulse, digitos_ingresados=0; clave_aceptada=1 while idle -> no effect.
REQ-033 Keys 1,2,enviar then reset=0 one cycle -> all outputs 0, ESPERA_PRIMER_DIGITO, no pulses.
